// File: rtl/sfx_sequencer_if.sv
// Game-side signals seen by the sound-effect sequencer: status/score/button/mute in, audio/busy out.
// master = control/top-level side, slave = the sequencer.
interface sfx_sequencer_if;
   logic [1:0]  status;
   logic [15:0] score;
   logic        up;
   logic        mute;
   logic        audio;
   logic        busy;

   modport master (output status, score, up, mute, input audio, busy);
   modport slave  (input status, score, up, mute, output audio, busy);
endinterface

// File: rtl/sfx_sequencer.sv
// Square-wave jingle player (FLAP / COIN / DEATH) driven by game events, notes from an internal ROM.
// Optional feature macro: SFX_FLAP_EN (flap blip detection and its ROM entry).
module sfx_sequencer #(
   parameter int NOTE_TICKS = 5_000_000,
   parameter int TONE_SHIFT = 0
) (
   input logic            clk,
   input logic            rst,
   sfx_sequencer_if.slave sfx
);
   typedef enum logic {ST_IDLE, ST_PLAY} state_e;

   // Encoding order is the priority order, so preemption is a plain >= compare.
   typedef enum logic [1:0] {
      FX_NONE  = 2'd0,
      FX_FLAP  = 2'd1,
      FX_COIN  = 2'd2,
      FX_DEATH = 2'd3
   } fx_e;

   // Entry = {half_period[17:0], units[2:0]}; half_period 0 is a rest.
   function automatic logic [20:0] note_rom(input fx_e fx, input logic [2:0] idx);
      logic [20:0] e;
      e = '0;
      case (fx)
`ifdef SFX_FLAP_EN
         FX_FLAP: e = {18'd56818, 3'd1};
`endif
         FX_COIN: begin
            case (idx)
               3'd0:    e = {18'd50607, 3'd1};
               default: e = {18'd37908, 3'd3};
            endcase
         end
         FX_DEATH: begin
            case (idx)
               3'd0:    e = {18'd113636, 3'd2};
               3'd1:    e = {18'd151515, 3'd2};
               3'd2:    e = {18'd0,      3'd1};
               3'd3:    e = {18'd190840, 3'd2};
               default: e = {18'd255102, 3'd4};
            endcase
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic logic [2:0] last_note(input fx_e fx);
      case (fx)
         FX_COIN:  return 3'd1;
         FX_DEATH: return 3'd4;
         default:  return 3'd0;
      endcase
   endfunction

   state_e      r_state;
   fx_e         r_fx;
   logic [2:0]  r_note;
   logic [31:0] r_dur_cnt;
   logic [17:0] r_tone_cnt;
   logic        r_tone;
   logic [15:0] r_score_q;
   logic [1:0]  r_status_q;

   state_e      w_state_nxt;
   fx_e         w_fx_nxt;
   logic [2:0]  w_note_nxt;
   logic        w_load;
   fx_e         w_new_fx;
   logic        w_start;
   logic        w_death;
   logic        w_coin;
   logic        w_flap;
   logic [20:0] w_rom;
   logic [17:0] w_half;
   logic [31:0] w_dur_limit;
   logic        w_dur_done;
   logic        w_last;

   assign w_rom       = note_rom(r_fx, r_note);
   assign w_half      = w_rom[20:3] >> TONE_SHIFT;
   assign w_dur_limit = 32'(w_rom[2:0]) * 32'(NOTE_TICKS) - 32'd1;
   assign w_dur_done  = (r_dur_cnt == w_dur_limit);
   assign w_last      = (r_note == last_note(r_fx));

   assign w_death = (r_status_q == 2'b01) && (sfx.status == 2'b10);
   assign w_coin  = (sfx.status == 2'b01) && (sfx.score != r_score_q);

`ifdef SFX_FLAP_EN
   logic r_up_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_up_q <= 1'b0;
      else      r_up_q <= sfx.up;
   end

   assign w_flap = (sfx.status == 2'b01) && sfx.up && !r_up_q;
`else
   assign w_flap = 1'b0;
`endif

   // NOTE: every state element uses non-blocking assignment so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_score_q  <= '0;
         r_status_q <= 2'b00;
      end else begin
         r_score_q  <= sfx.score;
         r_status_q <= sfx.status;
      end
   end

   always_comb begin
      w_new_fx = FX_NONE;
      if      (w_death) w_new_fx = FX_DEATH;
      else if (w_coin)  w_new_fx = FX_COIN;
      else if (w_flap)  w_new_fx = FX_FLAP;
   end

   assign w_start = (w_new_fx != FX_NONE) && ((r_state == ST_IDLE) || (w_new_fx >= r_fx));

   // NOTE: defaults are assigned first so no path leaves an output unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      w_fx_nxt    = r_fx;
      w_note_nxt  = r_note;
      w_load      = 1'b0;
      if (w_start) begin
         w_state_nxt = ST_PLAY;
         w_fx_nxt    = w_new_fx;
         w_note_nxt  = 3'd0;
         w_load      = 1'b1;
      end else if ((r_state == ST_PLAY) && w_dur_done) begin
         if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_fx_nxt    = FX_NONE;
            w_note_nxt  = 3'd0;
         end else begin
            w_note_nxt = r_note + 3'd1;
            w_load     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_fx    <= FX_NONE;
         r_note  <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_fx    <= w_fx_nxt;
         r_note  <= w_note_nxt;
      end
   end

   // Note and tone timers restart on every note load and are held clear while idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dur_cnt  <= '0;
         r_tone_cnt <= '0;
         r_tone     <= 1'b0;
      end else if (w_load || (w_state_nxt == ST_IDLE)) begin
         r_dur_cnt  <= '0;
         r_tone_cnt <= '0;
         r_tone     <= 1'b0;
      end else begin
         r_dur_cnt <= r_dur_cnt + 32'd1;
         if (w_half == 18'd0) begin
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
         end else if (r_tone_cnt == w_half - 18'd1) begin
            r_tone_cnt <= '0;
            r_tone     <= ~r_tone;
         end else begin
            r_tone_cnt <= r_tone_cnt + 18'd1;
         end
      end
   end

   assign sfx.busy  = (r_state == ST_PLAY);
   assign sfx.audio = r_tone & ~sfx.mute & (r_state == ST_PLAY);
endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer (NOTE_TICKS=100, TONE_SHIFT=10): expected audio/busy transitions are queued
// per triggered effect; a monitor pops one entry per observed output change and compares cycle and levels.
module tb_sfx_sequencer;
   logic clk;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

`ifdef SFX_FLAP_EN
   localparam bit FLAP_EN = 1'b1;
`else
   localparam bit FLAP_EN = 1'b0;
`endif

   sfx_sequencer_if bus ();

   sfx_sequencer #(.NOTE_TICKS(100), .TONE_SHIFT(10)) dut (
      .clk (clk),
      .rst (rst),
      .sfx (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      bit a;
      bit b;
   } evt_t;

   evt_t q[$];
   bit   exp_a = 1'b0;
   bit   exp_b = 1'b0;
   bit   mon_en = 1'b0;

   // Hand-computed note tables in clock cycles: half period (ROM>>10) and duration (units*100).
   int fx_half [3][5] = '{'{55, 0, 0, 0, 0}, '{49, 37, 0, 0, 0}, '{110, 147, 0, 186, 249}};
   int fx_dur  [3][5] = '{'{100, 0, 0, 0, 0}, '{100, 300, 0, 0, 0}, '{200, 200, 100, 200, 400}};
   int fx_n    [3]    = '{1, 2, 5};

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int t, input bit a, input bit b);
      evt_t e;
      e.cyc = t;
      e.a   = a;
      e.b   = b;
      q.push_back(e);
   endtask

   task automatic drop_from(input int t);
      while (q.size() > 0 && q[$].cyc >= t) void'(q.pop_back());
   endtask

   // Effect triggered now loads at the next edge; anything planned from then on is superseded.
   task automatic start_fx(input int fx, input bit muted);
      int t;
      bit a;
      t = cyc + 1;
      drop_from(t);
      if (exp_a || !exp_b) push(t, 1'b0, 1'b1);
      a = 1'b0;
      for (int i = 0; i < fx_n[fx]; i++) begin
         if (fx_half[fx][i] > 0) begin
            for (int k = 1; k * fx_half[fx][i] < fx_dur[fx][i]; k++) begin
               a = !a;
               if (!muted) push(t + k * fx_half[fx][i], a, 1'b1);
            end
         end
         t += fx_dur[fx][i];
         if (i == fx_n[fx] - 1) push(t, 1'b0, 1'b0);
         else if (a && !muted)  push(t, 1'b0, 1'b1);
         a = 1'b0;
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin : monitor
      evt_t e;
      logic prev_a;
      logic prev_b;
      prev_a = 1'b0;
      prev_b = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
               e = q.pop_front();
               exp_a = e.a;
               exp_b = e.b;
               check("evt_missed", cyc, e.cyc);
            end
            if (bus.audio !== prev_a || bus.busy !== prev_b) begin
               if (q.size() == 0) begin
                  check("evt_unexpected", cyc, -1);
               end else begin
                  e = q.pop_front();
                  exp_a = e.a;
                  exp_b = e.b;
                  check("evt_cycle", cyc, e.cyc);
                  check("evt_audio", int'(bus.audio), int'(e.a));
                  check("evt_busy", int'(bus.busy), int'(e.b));
               end
            end
            prev_a = bus.audio;
            prev_b = bus.busy;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int c;
      rst        = 1'b1;
      bus.status = 2'b00;
      bus.score  = 16'd3;
      bus.up     = 1'b0;
      bus.mute   = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("reset_audio", int'(bus.audio), 0);
      check("reset_busy", int'(bus.busy), 0);
      step(3);
      mon_en = 1'b1;
      rst    = 1'b1;
      step(3);
      bus.status = 2'b01;
      step(5);

      // FLAP: rising button edge while playing.
      bus.up = 1'b1;
      if (FLAP_EN) start_fx(0, 1'b0);
      step(1);
      bus.up = 1'b0;
      step(150);

      // COIN: score 3 -> 4.
      bus.score = 16'd4;
      start_fx(1, 1'b0);
      step(450);

      // Death and score change in the same cycle: DEATH only.
      bus.status = 2'b10;
      bus.score  = 16'd5;
      start_fx(2, 1'b0);
      step(300);
      bus.score = 16'd6;
      step(850);
      bus.status = 2'b00;
      step(2);
      bus.status = 2'b01;
      step(5);

      // COIN playing, button rises: lower priority, dropped.
      bus.score = 16'd7;
      start_fx(1, 1'b0);
      step(150);
      bus.up = 1'b1;
      step(1);
      bus.up = 1'b0;
      step(300);

      // FLAP playing, score changes: COIN preempts; then COIN retrigger restarts.
      bus.up = 1'b1;
      if (FLAP_EN) start_fx(0, 1'b0);
      step(1);
      bus.up = 1'b0;
      step(69);
      bus.score = 16'd8;
      start_fx(1, 1'b0);
      step(150);
      bus.score = 16'd9;
      start_fx(1, 1'b0);
      step(450);

      // Muted COIN: busy timing unchanged, audio silent.
      bus.mute  = 1'b1;
      bus.score = 16'd10;
      start_fx(1, 1'b1);
      step(450);
      bus.mute = 1'b0;

      // Score wrap 0xFFFF -> 0x0000 while playing is a coin.
      bus.score = 16'hFFFF;
      start_fx(1, 1'b0);
      step(450);
      bus.score = 16'h0000;
      start_fx(1, 1'b0);
      step(450);

      // Asynchronous reset mid-DEATH.
      bus.status = 2'b10;
      start_fx(2, 1'b0);
      step(250);
      c = cyc;
      drop_from(c + 1);
      push(c + 1, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      check("rst_mid_busy", int'(bus.busy), 0);
      check("rst_mid_audio", int'(bus.audio), 0);
      step(3);
      rst = 1'b1;
      step(300);
      check("post_rst_busy", int'(bus.busy), 0);

      // Status 11: no events at all.
      bus.status = 2'b11;
      step(2);
      bus.score = 16'd11;
      bus.up    = 1'b1;
      step(50);
      bus.up = 1'b0;
      step(20);

      for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge clk);
      step(2);
      check("queue_drained", q.size(), 0);
      check("final_busy", int'(bus.busy), 0);
      check("final_audio", int'(bus.audio), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
